// File: rtl/rv32im_dmem_bridge.sv
// Load/store bridge between an RV32IM LSU and a word-wide data memory.
// Handles byte/half/word lanes, sign extension and optional two-word split of misaligned accesses.
module rv32im_dmem_bridge #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_req_addr,
  input  logic [31:0] lsu_req_wdata,
  input  logic        lsu_req_we,
  input  logic [1:0]  lsu_req_size,
  input  logic        lsu_req_unsigned,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_resp_data,
  output logic        dmem_req_valid,
  output logic [31:0] dmem_req_addr,
  output logic [31:0] dmem_req_data,
  output logic [3:0]  dmem_req_write_en,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_resp_data
);

  typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_t;

  state_t      state;
  logic [31:0] addr_reg;
  logic [1:0]  off_reg;
  logic [2:0]  nbytes_reg;
  logic        we_reg;
  logic        unsigned_reg;
  logic        split_reg;
  logic [3:0]  hi_lanes_reg;
  logic [31:0] hi_data_reg;
  logic [31:0] word0_reg;

  logic [31:0] in_addr;
  logic [1:0]  in_off;
  logic [2:0]  in_nbytes;
  logic [3:0]  in_mask;
  logic        in_split;
  logic [3:0]  lo_lanes, hi_lanes;
  logic [31:0] lo_data, hi_data;

  always_comb begin
    in_addr = lsu_req_addr;
    if (!SPLIT_MISALIGNED) begin
      if (lsu_req_size[1])      in_addr[1:0] = 2'b00;
      else if (lsu_req_size[0]) in_addr[0]   = 1'b0;
    end
    in_off = in_addr[1:0];
    if (lsu_req_size[1]) begin
      in_nbytes = 3'd4;
      in_mask   = 4'b1111;
    end else if (lsu_req_size[0]) begin
      in_nbytes = 3'd2;
      in_mask   = 4'b0011;
    end else begin
      in_nbytes = 3'd1;
      in_mask   = 4'b0001;
    end
    in_split = SPLIT_MISALIGNED && (({1'b0, in_off} + in_nbytes) > 3'd4);
    // The high halves are what spill into the next word; zero when off = 0.
    lo_lanes = in_mask << in_off;
    hi_lanes = in_mask >> (3'd4 - {1'b0, in_off});
    lo_data  = lsu_req_wdata << {in_off, 3'b000};
    hi_data  = lsu_req_wdata >> (6'd32 - {1'b0, in_off, 3'b000});
  end

  function automatic logic [31:0] load_value(input logic [31:0] w0, input logic [31:0] w1,
                                             input logic [1:0] off, input logic [2:0] nb,
                                             input logic uns);
    logic [31:0] s;
    s = (w0 >> {off, 3'b000}) | (w1 << (6'd32 - {1'b0, off, 3'b000}));
    case (nb)
      3'd1:    load_value = uns ? {24'd0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      3'd2:    load_value = uns ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: load_value = s;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      lsu_req_ready     <= 1'b1;
      lsu_resp_valid    <= 1'b0;
      lsu_resp_data     <= 32'd0;
      dmem_req_valid    <= 1'b0;
      dmem_req_addr     <= 32'd0;
      dmem_req_data     <= 32'd0;
      dmem_req_write_en <= 4'd0;
      addr_reg          <= 32'd0;
      off_reg           <= 2'd0;
      nbytes_reg        <= 3'd0;
      we_reg            <= 1'b0;
      unsigned_reg      <= 1'b0;
      split_reg         <= 1'b0;
      hi_lanes_reg      <= 4'd0;
      hi_data_reg       <= 32'd0;
      word0_reg         <= 32'd0;
    end else begin
      dmem_req_valid    <= 1'b0;
      dmem_req_addr     <= 32'd0;
      dmem_req_data     <= 32'd0;
      dmem_req_write_en <= 4'd0;
      lsu_resp_valid    <= 1'b0;
      lsu_resp_data     <= 32'd0;
      case (state)
        IDLE: begin
          if (lsu_req_valid && lsu_req_ready) begin
            addr_reg          <= {in_addr[31:2], 2'b00};
            off_reg           <= in_off;
            nbytes_reg        <= in_nbytes;
            we_reg            <= lsu_req_we;
            unsigned_reg      <= lsu_req_unsigned;
            split_reg         <= in_split;
            hi_lanes_reg      <= hi_lanes;
            hi_data_reg       <= hi_data;
            lsu_req_ready     <= 1'b0;
            dmem_req_valid    <= 1'b1;
            dmem_req_addr     <= {in_addr[31:2], 2'b00};
            dmem_req_data     <= lo_data;
            dmem_req_write_en <= lsu_req_we ? lo_lanes : 4'd0;
            state             <= ISSUE0;
          end
        end
        ISSUE0: begin
          if (!we_reg) begin
            state <= WAIT0;
          end else if (split_reg) begin
            dmem_req_valid    <= 1'b1;
            dmem_req_addr     <= addr_reg + 32'd4;
            dmem_req_data     <= hi_data_reg;
            dmem_req_write_en <= hi_lanes_reg;
            state             <= ISSUE1;
          end else begin
            lsu_resp_valid <= 1'b1;
            state          <= RESP;
          end
        end
        WAIT0: begin
          if (dmem_resp_valid) begin
            if (split_reg) begin
              word0_reg      <= dmem_resp_data;
              dmem_req_valid <= 1'b1;
              dmem_req_addr  <= addr_reg + 32'd4;
              dmem_req_data  <= hi_data_reg;
              state          <= ISSUE1;
            end else begin
              lsu_resp_valid <= 1'b1;
              lsu_resp_data  <= load_value(dmem_resp_data, 32'd0, off_reg, nbytes_reg, unsigned_reg);
              state          <= RESP;
            end
          end
        end
        ISSUE1: begin
          if (we_reg) begin
            lsu_resp_valid <= 1'b1;
            state          <= RESP;
          end else begin
            state <= WAIT1;
          end
        end
        WAIT1: begin
          if (dmem_resp_valid) begin
            lsu_resp_valid <= 1'b1;
            lsu_resp_data  <= load_value(word0_reg, dmem_resp_data, off_reg, nbytes_reg, unsigned_reg);
            state          <= RESP;
          end
        end
        RESP: begin
          lsu_req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          lsu_req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32im_dmem_bridge.sv
// Directed bench for rv32im_dmem_bridge: vector table of LSU transactions with a
// small memory responder, plus a mid-operation reset sequence.
module tb_rv32im_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_wdata;
  logic        lsu_req_we;
  logic [1:0]  lsu_req_size;
  logic        lsu_req_unsigned;
  logic        lsu_resp_valid;
  logic [31:0] lsu_resp_data;
  logic        dmem_req_valid;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_data;
  logic [3:0]  dmem_req_write_en;
  logic        dmem_resp_valid;
  logic [31:0] dmem_resp_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rv32im_dmem_bridge #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
    .lsu_req_we(lsu_req_we), .lsu_req_size(lsu_req_size),
    .lsu_req_unsigned(lsu_req_unsigned),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_addr(dmem_req_addr),
    .dmem_req_data(dmem_req_data), .dmem_req_write_en(dmem_req_write_en),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] mem0;
    logic [31:0] mem1;
    int          wait_cyc;
    int          nacc;
    logic [31:0] a0;
    logic [3:0]  w0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  w1;
    logic [31:0] d1;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                              input logic [1:0] size, input logic uns, input logic [31:0] mem0,
                              input logic [31:0] mem1, input int wait_cyc, input int nacc,
                              input logic [31:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                              input logic [31:0] a1, input logic [3:0] w1, input logic [31:0] d1,
                              input logic [31:0] rdata, input int lat);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.we = we; v.size = size; v.uns = uns;
    v.mem0 = mem0; v.mem1 = mem1; v.wait_cyc = wait_cyc; v.nacc = nacc;
    v.a0 = a0; v.w0 = w0; v.d0 = d0; v.a1 = a1; v.w1 = w1; v.d1 = d1;
    v.rdata = rdata; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int          nacc = 0;
    int          nread = 0;
    int          nresp = 0;
    int          cnt = 0;
    int          lat = 0;
    bit          pend = 0;
    bit          bad_idle = 0;
    bit          busy_ready = 0;
    bit          ready_after = 0;
    logic [31:0] a[2];
    logic [3:0]  w[2];
    logic [31:0] d[2];
    logic [31:0] rdata = 32'd0;
    for (int k = 0; k < 2; k++) begin a[k] = 32'hDEAD_DEAD; w[k] = 4'hF; d[k] = 32'hDEAD_DEAD; end

    @(negedge clk);
    chk($sformatf("v%0d_ready_idle", idx), 32'(lsu_req_ready), 32'd1);
    lsu_req_valid = 1'b1; lsu_req_addr = v.addr; lsu_req_wdata = v.wdata;
    lsu_req_we = v.we; lsu_req_size = v.size; lsu_req_unsigned = v.uns;
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;

    for (int cyc = 1; cyc <= 25; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      dmem_resp_valid = 1'b0;
      dmem_resp_data  = 32'd0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          dmem_resp_valid = 1'b1;
          dmem_resp_data  = (nread == 1) ? v.mem0 : v.mem1;
          pend = 0;
        end
      end
      if (dmem_req_valid) begin
        if (nacc < 2) begin a[nacc] = dmem_req_addr; w[nacc] = dmem_req_write_en; d[nacc] = dmem_req_data; end
        nacc++;
        if (dmem_req_write_en == 4'd0) begin nread++; pend = 1; cnt = v.wait_cyc + 1; end
      end else if (dmem_req_addr != 32'd0 || dmem_req_data != 32'd0 || dmem_req_write_en != 4'd0) begin
        bad_idle = 1;
      end
      if (lsu_resp_valid) begin
        nresp++;
        if (lat == 0) begin lat = cyc; rdata = lsu_resp_data; end
      end
      if (lat != 0 && cyc == lat + 1) begin
        ready_after = lsu_req_ready;
        break;
      end
      if (lat == 0 && lsu_req_ready) busy_ready = 1;
    end
    dmem_resp_valid = 1'b0;
    dmem_resp_data  = 32'd0;

    $display("txn %0d addr=%h we=%0d size=%0d accesses=%0d lat=%0d rdata=%h",
             idx, v.addr, v.we, v.size, nacc, lat, rdata);
    chk($sformatf("v%0d_nacc", idx), 32'(nacc), 32'(v.nacc));
    chk($sformatf("v%0d_addr0", idx), a[0], v.a0);
    chk($sformatf("v%0d_we0", idx), 32'(w[0]), 32'(v.w0));
    chk($sformatf("v%0d_data0", idx), d[0], v.d0);
    if (v.nacc == 2) begin
      chk($sformatf("v%0d_addr1", idx), a[1], v.a1);
      chk($sformatf("v%0d_we1", idx), 32'(w[1]), 32'(v.w1));
      chk($sformatf("v%0d_data1", idx), d[1], v.d1);
    end
    chk($sformatf("v%0d_rdata", idx), rdata, v.rdata);
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_resp_pulses", idx), 32'(nresp), 32'd1);
    chk($sformatf("v%0d_idle_outputs_zero", idx), 32'(bad_idle), 32'd0);
    chk($sformatf("v%0d_ready_while_busy", idx), 32'(busy_ready), 32'd0);
    chk($sformatf("v%0d_ready_after", idx), 32'(ready_after), 32'd1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; lsu_req_valid = 1'b0; lsu_req_addr = 32'd0; lsu_req_wdata = 32'd0;
    lsu_req_we = 1'b0; lsu_req_size = 2'd0; lsu_req_unsigned = 1'b0;
    dmem_resp_valid = 1'b0; dmem_resp_data = 32'd0;

    //            addr          wdata         we    sz    uns   mem0          mem1          wt n  a0            we0      d0            a1            we1      d1            rdata         lat
    vecs[0]  = mk(32'h0000_1003, 32'h0000_00A5, 1'b1, 2'd0, 1'b0, 32'd0,        32'd0,        0, 1, 32'h0000_1000, 4'b1000, 32'hA500_0000, 32'd0,        4'd0,    32'd0,        32'd0,        2);
    vecs[1]  = mk(32'h0000_2002, 32'd0,         1'b0, 2'd1, 1'b0, 32'h8001_1234, 32'd0,        0, 1, 32'h0000_2000, 4'b0000, 32'd0,        32'd0,        4'd0,    32'd0,        32'hFFFF_8001, 3);
    vecs[2]  = mk(32'h0000_2002, 32'd0,         1'b0, 2'd1, 1'b1, 32'h8001_1234, 32'd0,        0, 1, 32'h0000_2000, 4'b0000, 32'd0,        32'd0,        4'd0,    32'd0,        32'h0000_8001, 3);
    vecs[3]  = mk(32'h0000_3003, 32'h1122_3344, 1'b1, 2'd2, 1'b0, 32'd0,        32'd0,        0, 2, 32'h0000_3000, 4'b1000, 32'h4400_0000, 32'h0000_3004, 4'b0111, 32'h0011_2233, 32'd0,        3);
    vecs[4]  = mk(32'h0000_4001, 32'd0,         1'b0, 2'd2, 1'b0, 32'hDDCC_BBAA, 32'h4433_2211, 0, 2, 32'h0000_4000, 4'b0000, 32'd0,        32'h0000_4004, 4'b0000, 32'd0,        32'h11DD_CCBB, 5);
    vecs[5]  = mk(32'hFFFF_FFFE, 32'd0,         1'b0, 2'd2, 1'b0, 32'h5566_7788, 32'h1122_3344, 0, 2, 32'hFFFF_FFFC, 4'b0000, 32'd0,        32'h0000_0000, 4'b0000, 32'd0,        32'h3344_5566, 5);
    vecs[6]  = mk(32'h0000_5001, 32'd0,         1'b0, 2'd0, 1'b0, 32'h0000_80FF, 32'd0,        2, 1, 32'h0000_5000, 4'b0000, 32'd0,        32'd0,        4'd0,    32'd0,        32'hFFFF_FF80, 5);
    vecs[7]  = mk(32'h0000_5001, 32'd0,         1'b0, 2'd0, 1'b1, 32'h0000_80FF, 32'd0,        0, 1, 32'h0000_5000, 4'b0000, 32'd0,        32'd0,        4'd0,    32'd0,        32'h0000_0080, 3);
    vecs[8]  = mk(32'h0000_6001, 32'h0000_BEEF, 1'b1, 2'd1, 1'b0, 32'd0,        32'd0,        0, 1, 32'h0000_6000, 4'b0110, 32'h00BE_EF00, 32'd0,        4'd0,    32'd0,        32'd0,        2);
    vecs[9]  = mk(32'h0000_6003, 32'h0000_BEEF, 1'b1, 2'd1, 1'b0, 32'd0,        32'd0,        0, 2, 32'h0000_6000, 4'b1000, 32'hEF00_0000, 32'h0000_6004, 4'b0001, 32'h0000_00BE, 32'd0,        3);
    vecs[10] = mk(32'h0000_7000, 32'hCAFE_F00D, 1'b1, 2'd3, 1'b0, 32'd0,        32'd0,        0, 1, 32'h0000_7000, 4'b1111, 32'hCAFE_F00D, 32'd0,        4'd0,    32'd0,        32'd0,        2);
    vecs[11] = mk(32'h0000_8000, 32'd0,         1'b0, 2'd2, 1'b0, 32'h1234_5678, 32'd0,        1, 1, 32'h0000_8000, 4'b0000, 32'd0,        32'd0,        4'd0,    32'd0,        32'h1234_5678, 4);
    vecs[12] = mk(32'h0000_9003, 32'd0,         1'b0, 2'd1, 1'b0, 32'hAB00_0000, 32'h0000_00CD, 0, 2, 32'h0000_9000, 4'b0000, 32'd0,        32'h0000_9004, 4'b0000, 32'd0,        32'hFFFF_CDAB, 5);
    vecs[13] = mk(32'h0000_A000, 32'd0,         1'b0, 2'd0, 1'b0, 32'h0000_007F, 32'd0,        0, 1, 32'h0000_A000, 4'b0000, 32'd0,        32'd0,        4'd0,    32'd0,        32'h0000_007F, 3);
    vecs[14] = mk(32'h0000_C002, 32'd0,         1'b0, 2'd2, 1'b1, 32'h7766_5544, 32'hBBAA_9988, 1, 2, 32'h0000_C000, 4'b0000, 32'd0,        32'h0000_C004, 4'b0000, 32'd0,        32'h9988_7766, 7);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_ready", 32'(lsu_req_ready), 32'd1);
    chk("reset_resp_valid", 32'(lsu_resp_valid), 32'd0);
    chk("reset_resp_data", lsu_resp_data, 32'd0);
    chk("reset_dmem_valid", 32'(dmem_req_valid), 32'd0);
    chk("reset_dmem_addr", dmem_req_addr, 32'd0);
    chk("reset_dmem_we", 32'(dmem_req_write_en), 32'd0);

    for (int i = 0; i < 15; i++) run_txn(vecs[i], i);

    // Reset while waiting on a load, with its read data turning up afterwards.
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h0000_B000; lsu_req_wdata = 32'd0;
    lsu_req_we = 1'b0; lsu_req_size = 2'd2; lsu_req_unsigned = 1'b0;
    @(posedge clk); #1;
    lsu_req_valid = 1'b0;
    chk("rst_seq_issue0", 32'(dmem_req_valid), 32'd1);
    @(posedge clk); #1;
    chk("rst_seq_wait0", 32'(dmem_req_valid), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_resp_valid = 1'b1; dmem_resp_data = 32'h0000_0055;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      dmem_resp_valid = 1'b0; dmem_resp_data = 32'd0;
      if (lsu_resp_valid || dmem_req_valid) seen = 1;
    end
    $display("txn rst_seq addr=0000b000 reset in WAIT0, stray resp_valid after release");
    chk("rst_seq_no_activity", 32'(seen), 32'd0);
    chk("rst_seq_ready", 32'(lsu_req_ready), 32'd1);
    run_txn(vecs[0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
